efuse_macro_model: RTL and testbench

// - Responder side of the efuse macro interface: cycle-accurate RTL model of a 256-bit OTP efuse array.
// - Driven by the controller's pgmen/rden/aen/addr outputs; returns 8-bit read data.
// - Checks strobe timing and protocol; flags violations for the bench.
// - Sits in place of the hard macro in simulation and FPGA builds of the efuse subsystem.

---
 rtl/efuse_macro_model.sv | 218 +++++++++++++++++++++
 tb/tb_efuse_macro_model.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_macro_model.sv
// efuse_macro_model: cycle-accurate responder model of a 256-bit one-time-programmable
// efuse array. It accepts read/program strobes from the efuse controller, returns
// registered 8-bit read data, and records the first protocol/timing violation seen.
// Build option: define EFUSE_MODEL_TCHK_EN to enable strobe-width checks
// (short read, short program, over-long program). Without it, any strobe of one
// or more cycles completes normally.
`timescale 1ns/1ps

module efuse_macro_model #(
    parameter logic [255:0] INIT_VAL = '0,
    parameter int           TRD_MIN  = 2,
    parameter int           TPGM_MIN = 2,
    parameter int           TPGM_MAX = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         efuse_pgmen_i,
    input  logic         efuse_rden_i,
    input  logic         efuse_aen_i,
    input  logic [7:0]   efuse_addr_i,
    output logic [7:0]   efuse_rdata_o,
    input  logic         model_err_clr_i,
    output logic         model_err_o,
    output logic [2:0]   model_err_code_o,
    output logic [15:0]  model_rd_cnt_o,
    output logic [15:0]  model_pgm_cnt_o,
    output logic [255:0] model_array_o
);

`ifdef EFUSE_MODEL_TCHK_EN
    localparam bit TCHK_EN = 1'b1;
`else
    localparam bit TCHK_EN = 1'b0;
`endif

    localparam logic [9:0] TRD_MIN_C  = 10'(TRD_MIN);
    localparam logic [9:0] TPGM_MIN_C = 10'(TPGM_MIN);
    localparam logic [9:0] TPGM_MAX_C = 10'(TPGM_MAX);
    localparam logic [9:0] CNT_SAT    = 10'd1023;

    // Error codes reported on model_err_code_o
    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_RD_SHORT = 3'd1;
    localparam logic [2:0] E_PG_SHORT = 3'd2;
    localparam logic [2:0] E_PG_LONG  = 3'd3;
    localparam logic [2:0] E_ADDR_CHG = 3'd4;
    localparam logic [2:0] E_CONFLICT = 3'd5;
    localparam logic [2:0] E_MODE_CHG = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_STB = 2'd1,
        ST_PG_STB = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    state_t         r_state;
    logic [7:0]     r_addr;
    logic [9:0]     r_cnt;
    logic [255:0]   r_array;
    logic [7:0]     r_rdata;
    logic           r_err;
    logic [2:0]     r_code;
    logic [15:0]    r_rd_cnt;
    logic [15:0]    r_pgm_cnt;

    logic           w_addr_chg;
    logic           w_mode_chg;
    logic           w_rd_short;
    logic           w_pg_short;
    logic           w_pg_long;
    logic [2:0]     w_err_code;
    logic           w_err_hit;
    logic [9:0]     w_cnt_inc;

    // Saturating strobe-width counter increment
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 10'd1;
    assign w_err_hit = (w_err_code != E_NONE);

    // Classify this cycle's violation, if any. Abort checks (address/mode) only
    // apply while the strobe is high; once aen falls the strobe is over and the
    // controller may release address and enables in the same cycle. When address
    // and mode change together, the higher code (mode change) wins.
    always_comb begin
        w_addr_chg = (efuse_addr_i != r_addr);
        w_rd_short = TCHK_EN && (r_cnt < TRD_MIN_C);
        w_pg_short = TCHK_EN && (r_cnt < TPGM_MIN_C);
        w_pg_long  = TCHK_EN && (r_cnt > TPGM_MAX_C);
        w_mode_chg = 1'b0;
        w_err_code = E_NONE;
        case (r_state)
            ST_IDLE: begin
                if (efuse_aen_i && efuse_rden_i && efuse_pgmen_i) begin
                    w_err_code = E_CONFLICT;
                end
            end
            ST_RD_STB: begin
                if (efuse_aen_i) begin
                    w_mode_chg = !efuse_rden_i || efuse_pgmen_i;
                    if (w_mode_chg) begin
                        w_err_code = E_MODE_CHG;
                    end else if (w_addr_chg) begin
                        w_err_code = E_ADDR_CHG;
                    end
                end else if (w_rd_short) begin
                    w_err_code = E_RD_SHORT;
                end
            end
            ST_PG_STB: begin
                if (efuse_aen_i) begin
                    w_mode_chg = !efuse_pgmen_i || efuse_rden_i;
                    if (w_mode_chg) begin
                        w_err_code = E_MODE_CHG;
                    end else if (w_addr_chg) begin
                        w_err_code = E_ADDR_CHG;
                    end
                end else if (w_pg_short) begin
                    w_err_code = E_PG_SHORT;
                end else if (w_pg_long) begin
                    w_err_code = E_PG_LONG;
                end
            end
            default: begin
            end
        endcase
    end

    // Strobe FSM, fuse array, read data, counters and sticky error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_array   <= INIT_VAL;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_code    <= E_NONE;
            r_rd_cnt  <= '0;
            r_pgm_cnt <= '0;
        end else begin
            // A new error overrides a same-cycle clear; otherwise the first one sticks.
            if (w_err_hit && (!r_err || model_err_clr_i)) begin
                r_err  <= 1'b1;
                r_code <= w_err_code;
            end else if (model_err_clr_i) begin
                r_err  <= 1'b0;
                r_code <= E_NONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (efuse_aen_i) begin
                        if (efuse_rden_i && efuse_pgmen_i) begin
                            r_state <= ST_ABORT;
                        end else if (efuse_rden_i) begin
                            r_addr  <= efuse_addr_i;
                            r_cnt   <= 10'd1;
                            r_state <= ST_RD_STB;
                        end else if (efuse_pgmen_i) begin
                            r_addr  <= efuse_addr_i;
                            r_cnt   <= 10'd1;
                            r_state <= ST_PG_STB;
                        end
                    end
                end
                ST_RD_STB: begin
                    if (efuse_aen_i) begin
                        if (w_err_hit) begin
                            r_state <= ST_ABORT;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        if (!w_rd_short) begin
                            r_rdata  <= r_array[{r_addr[7:3], 3'b000} +: 8];
                            r_rd_cnt <= r_rd_cnt + 16'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_PG_STB: begin
                    if (efuse_aen_i) begin
                        if (w_err_hit) begin
                            r_state <= ST_ABORT;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        // Over-long strobes still blow the fuse but are not counted as good.
                        if (!w_pg_short) begin
                            r_array[r_addr] <= 1'b1;
                            if (!w_pg_long) begin
                                r_pgm_cnt <= r_pgm_cnt + 16'd1;
                            end
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (!efuse_aen_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign efuse_rdata_o    = r_rdata;
    assign model_err_o      = r_err;
    assign model_err_code_o = r_code;
    assign model_rd_cnt_o   = r_rd_cnt;
    assign model_pgm_cnt_o  = r_pgm_cnt;
    assign model_array_o    = r_array;

endmodule

// File: tb/tb_efuse_macro_model.sv
// Testbench for efuse_macro_model: directed scenarios followed by random
// read/program/abort/clear traffic. Each transaction updates a transaction-level
// reference model and pushes the expected visible state into a scoreboard; a
// monitor on the falling edge pops and compares it against the DUT outputs.
`timescale 1ns/1ps

module tb_efuse_macro_model;

    localparam logic [255:0] INIT = 256'h0123456789ABCDEF_0000000000000000_0000000000000000_00000000000000F0;
    localparam int TRD   = 2;
    localparam int TPMIN = 2;
    localparam int TPMAX = 5;
`ifdef EFUSE_MODEL_TCHK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pgmen = 1'b0;
    logic         rden = 1'b0;
    logic         aen = 1'b0;
    logic         clr = 1'b0;
    logic [7:0]   addr = 8'h00;
    logic [7:0]   rdata;
    logic         err;
    logic [2:0]   code;
    logic [15:0]  rd_cnt;
    logic [15:0]  pgm_cnt;
    logic [255:0] arr;

    always #5 clk = ~clk;

    efuse_macro_model #(
        .INIT_VAL (INIT),
        .TRD_MIN  (TRD),
        .TPGM_MIN (TPMIN),
        .TPGM_MAX (TPMAX)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .efuse_pgmen_i    (pgmen),
        .efuse_rden_i     (rden),
        .efuse_aen_i      (aen),
        .efuse_addr_i     (addr),
        .efuse_rdata_o    (rdata),
        .model_err_clr_i  (clr),
        .model_err_o      (err),
        .model_err_code_o (code),
        .model_rd_cnt_o   (rd_cnt),
        .model_pgm_cnt_o  (pgm_cnt),
        .model_array_o    (arr)
    );

    typedef struct {
        string        tag;
        logic [7:0]   rdata;
        logic         err;
        logic [2:0]   code;
        logic [15:0]  rd_cnt;
        logic [15:0]  pgm_cnt;
        logic [255:0] arr;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_txn = 0;

    // Reference model state (transaction level)
    logic [255:0] m_arr;
    logic [7:0]   m_rdata;
    logic         m_err;
    logic [2:0]   m_code;
    logic [15:0]  m_rd;
    logic [15:0]  m_pg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the expected snapshot once the DUT result is due
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_txn++;
            check({mon_e.tag, " rdata"},   256'(rdata),   256'(mon_e.rdata));
            check({mon_e.tag, " err"},     256'(err),     256'(mon_e.err));
            check({mon_e.tag, " code"},    256'(code),    256'(mon_e.code));
            check({mon_e.tag, " rd_cnt"},  256'(rd_cnt),  256'(mon_e.rd_cnt));
            check({mon_e.tag, " pgm_cnt"}, 256'(pgm_cnt), 256'(mon_e.pgm_cnt));
            check({mon_e.tag, " array"},   arr,           mon_e.arr);
            $display("[TB] txn %0d %s: rdata=%02h err=%0d code=%0d rd=%0d pg=%0d",
                     n_txn, mon_e.tag, rdata, err, code, rd_cnt, pgm_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string tag);
        exp_t e;
        e.tag     = tag;
        e.rdata   = m_rdata;
        e.err     = m_err;
        e.code    = m_code;
        e.rd_cnt  = m_rd;
        e.pgm_cnt = m_pg;
        e.arr     = m_arr;
        e.due     = cyc;
        sb.push_back(e);
    endtask

    task automatic m_reset();
        m_arr   = INIT;
        m_rdata = 8'h00;
        m_err   = 1'b0;
        m_code  = 3'd0;
        m_rd    = 16'd0;
        m_pg    = 16'd0;
    endtask

    task automatic m_err_set(logic [2:0] c);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = c;
        end
    endtask

    task automatic do_read(logic [7:0] a, int len);
        logic [255:0] sh;
        rden = 1'b1; addr = a; aen = 1'b1;
        repeat (len) tick();
        aen = 1'b0; rden = 1'b0;
        tick();
        if (TCHK && len < TRD) begin
            m_err_set(3'd1);
        end else begin
            sh      = m_arr >> (8 * int'(a / 8));
            m_rdata = sh[7:0];
            m_rd    = m_rd + 16'd1;
        end
        push($sformatf("read a=%02h len=%0d", a, len));
    endtask

    task automatic do_prog(logic [7:0] a, int len);
        pgmen = 1'b1; addr = a; aen = 1'b1;
        repeat (len) tick();
        aen = 1'b0; pgmen = 1'b0;
        tick();
        if (TCHK && len < TPMIN) begin
            m_err_set(3'd2);
        end else begin
            m_arr = m_arr | (256'd1 << a);
            if (TCHK && len > TPMAX) m_err_set(3'd3);
            else m_pg = m_pg + 16'd1;
        end
        push($sformatf("prog a=%02h len=%0d", a, len));
    endtask

    task automatic do_conflict(int len, bit with_clr);
        rden = 1'b1; pgmen = 1'b1; addr = 8'(len); aen = 1'b1; clr = with_clr;
        tick();
        clr = 1'b0;
        repeat (len - 1) tick();
        aen = 1'b0; rden = 1'b0; pgmen = 1'b0;
        tick();
        if (with_clr) begin
            m_err  = 1'b1;
            m_code = 3'd5;
        end else begin
            m_err_set(3'd5);
        end
        push($sformatf("conflict len=%0d clr=%0d", len, with_clr));
    endtask

    // Start a strobe, hold it k cycles, then disturb address and/or enables
    task automatic do_abort(bit is_rd, logic [7:0] a, int k, logic [7:0] a2,
                            bit drop_own, bit raise_other, int extra);
        if (is_rd) rden = 1'b1; else pgmen = 1'b1;
        addr = a; aen = 1'b1;
        repeat (k) tick();
        addr = a2;
        if (drop_own) begin
            if (is_rd) rden = 1'b0; else pgmen = 1'b0;
        end
        if (raise_other) begin
            if (is_rd) pgmen = 1'b1; else rden = 1'b1;
        end
        tick();
        repeat (extra) tick();
        aen = 1'b0; rden = 1'b0; pgmen = 1'b0;
        tick();
        if (drop_own || raise_other) m_err_set(3'd6);
        else if (a2 != a) m_err_set(3'd4);
        push($sformatf("abort rd=%0d a=%02h->%02h drop=%0d raise=%0d", is_rd, a, a2, drop_own, raise_other));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_err  = 1'b0;
        m_code = 3'd0;
        push("clear");
    endtask

    task automatic do_reset_mid(logic [7:0] a);
        pgmen = 1'b1; addr = a; aen = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        aen = 1'b0; pgmen = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m_reset();
        push($sformatf("reset mid-prog a=%02h", a));
    endtask

    // Watchdog: the run must never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d pending required 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        logic [7:0] a, a2;
        bit drop, raise;
        m_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        push("after reset");

        // Directed scenarios
        do_read(8'h00, 3);
        do_prog(8'h09, 3);
        do_read(8'h08, 2);
        do_read(8'h00, 1);
        do_clr();
        do_conflict(2, 1'b0);
        do_clr();
        do_abort(1'b0, 8'h10, 1, 8'h11, 1'b0, 1'b0, 1);
        do_read(8'h10, 2);
        do_clr();
        do_abort(1'b1, 8'h20, 2, 8'h21, 1'b1, 1'b0, 0);
        do_conflict(2, 1'b1);
        do_clr();
        do_reset_mid(8'h20);
        do_prog(8'h00, 7);
        do_clr();
        do_prog(8'h09, 2);
        do_prog(8'h09, 3);
        do_read(8'h08, 3);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 9);
            a    = 8'($urandom_range(0, 255));
            if (kind <= 2) begin
                do_read(a, $urandom_range(1, 4));
            end else if (kind <= 5) begin
                do_prog(a, $urandom_range(1, 8));
            end else if (kind <= 7) begin
                a2    = ($urandom_range(0, 1) == 1) ? (a ^ 8'(1 << $urandom_range(0, 7))) : a;
                drop  = 1'($urandom_range(0, 1));
                raise = 1'($urandom_range(0, 1));
                if (!drop && !raise && a2 == a) a2 = a ^ 8'h01;
                do_abort(1'($urandom_range(0, 1)), a, $urandom_range(1, 3), a2, drop, raise,
                         $urandom_range(0, 2));
            end else if (kind == 8) begin
                do_clr();
            end else begin
                do_conflict($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 1)) tick();
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
